// File: rtl/tri_raster_scan.sv
// Triangle scan-converter: bounding-box walk with incremental edge functions.
// Accepts one triangle per handshake and emits one covered pixel per cycle,
// with flat colour/depth and orientation-normalised barycentric edge values.
module tri_raster_scan #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int COORD_W  = 12,
    parameter int ADDR_W   = 26,
    parameter int COLOR_W  = 24,
    parameter int DEPTH_W  = 32,
    parameter int EDGE_W   = 2*COORD_W+3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic [COORD_W-1:0] x2,
    input  logic [COORD_W-1:0] y2,
    input  logic [COORD_W-1:0] x3,
    input  logic [COORD_W-1:0] y3,
    input  logic [COLOR_W-1:0] color_in,
    input  logic [DEPTH_W-1:0] depth_in,
    input  logic [ADDR_W-1:0]  base_addr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_addr,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic [COLOR_W-1:0] out_color,
    output logic [DEPTH_W-1:0] out_depth,
    output logic [EDGE_W-1:0]  out_w1,
    output logic [EDGE_W-1:0]  out_w2,
    output logic [EDGE_W-1:0]  out_w3,
    output logic [EDGE_W-1:0]  out_area,
    output logic               tri_done,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, SETUP, SCAN, DRAIN} state_t;

    localparam logic signed [COORD_W-1:0] X_LIM = COORD_W'(SCREEN_W - 1);
    localparam logic signed [COORD_W-1:0] Y_LIM = COORD_W'(SCREEN_H - 1);
    localparam logic [ADDR_W-1:0]         ROW_PITCH = ADDR_W'(SCREEN_W);

    state_t state_reg;
    logic   tri_done_reg;

    // latched triangle
    logic signed [COORD_W-1:0] vx_reg [3];
    logic signed [COORD_W-1:0] vy_reg [3];
    logic [COLOR_W-1:0]        color_reg;
    logic [DEPTH_W-1:0]        depth_reg;
    logic [ADDR_W-1:0]         base_reg;

    // scan position and edge state
    logic signed [COORD_W-1:0] x_reg, y_reg, xmin_reg, xmax_reg, ymax_reg;
    logic signed [EDGE_W-1:0]  w_reg   [3];
    logic signed [EDGE_W-1:0]  row_reg [3];
    logic signed [EDGE_W-1:0]  sx_reg  [3];
    logic signed [EDGE_W-1:0]  sy_reg  [3];
    logic signed [EDGE_W-1:0]  area_reg;

    // output register
    logic                out_valid_reg;
    logic [ADDR_W-1:0]   out_addr_reg;
    logic [COORD_W-1:0]  out_x_reg, out_y_reg;
    logic [COLOR_W-1:0]  out_color_reg;
    logic [DEPTH_W-1:0]  out_depth_reg;
    logic [EDGE_W-1:0]   out_w_reg [3];
    logic [EDGE_W-1:0]   out_area_reg;

    function automatic logic signed [COORD_W-1:0] smin3(
        input logic signed [COORD_W-1:0] a,
        input logic signed [COORD_W-1:0] b,
        input logic signed [COORD_W-1:0] c);
        logic signed [COORD_W-1:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic signed [COORD_W-1:0] smax3(
        input logic signed [COORD_W-1:0] a,
        input logic signed [COORD_W-1:0] b,
        input logic signed [COORD_W-1:0] c);
        logic signed [COORD_W-1:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // ---------------- setup arithmetic (valid while in SETUP) ----------------
    logic signed [COORD_W-1:0] lo_x, hi_x, lo_y, hi_y;
    logic signed [COORD_W-1:0] bb_xmin, bb_xmax, bb_ymin, bb_ymax;
    logic signed [EDGE_W-1:0]  dxs [3];
    logic signed [EDGE_W-1:0]  dys [3];
    logic signed [EDGE_W-1:0]  e_org  [3];
    logic signed [EDGE_W-1:0]  e_init [3];
    logic signed [EDGE_W-1:0]  step_x [3];
    logic signed [EDGE_W-1:0]  step_y [3];
    logic signed [EDGE_W-1:0]  area_raw;
    logic                      neg, degenerate;

    assign lo_x = smin3(vx_reg[0], vx_reg[1], vx_reg[2]);
    assign hi_x = smax3(vx_reg[0], vx_reg[1], vx_reg[2]);
    assign lo_y = smin3(vy_reg[0], vy_reg[1], vy_reg[2]);
    assign hi_y = smax3(vy_reg[0], vy_reg[1], vy_reg[2]);

    assign bb_xmin = lo_x[COORD_W-1] ? '0 : lo_x;
    assign bb_ymin = lo_y[COORD_W-1] ? '0 : lo_y;
    assign bb_xmax = (hi_x > X_LIM) ? X_LIM : hi_x;
    assign bb_ymax = (hi_y > Y_LIM) ? Y_LIM : hi_y;

    // Edge gi runs from vertex (gi+1)%3 to (gi+2)%3, so edge 0 is E23 and
    // weights vertex 1, edge 1 is E31, edge 2 is E12.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_edge
            localparam int I = (gi + 1) % 3;
            localparam int J = (gi + 2) % 3;
            assign dxs[gi]   = EDGE_W'(vx_reg[J]) - EDGE_W'(vx_reg[I]);
            assign dys[gi]   = EDGE_W'(vy_reg[J]) - EDGE_W'(vy_reg[I]);
            assign e_org[gi] = (EDGE_W'(bb_xmin) - EDGE_W'(vx_reg[I])) * dys[gi]
                             - (EDGE_W'(bb_ymin) - EDGE_W'(vy_reg[I])) * dxs[gi];
            assign e_init[gi] = neg ? -e_org[gi] : e_org[gi];
            assign step_x[gi] = neg ? -dys[gi]   : dys[gi];
            assign step_y[gi] = neg ? dxs[gi]    : -dxs[gi];
        end
    endgenerate

    // Twice the signed area: E12 evaluated at vertex 3
    assign area_raw = (EDGE_W'(vx_reg[2]) - EDGE_W'(vx_reg[0])) * dys[2]
                    - (EDGE_W'(vy_reg[2]) - EDGE_W'(vy_reg[0])) * dxs[2];
    assign neg        = area_raw[EDGE_W-1];
    assign degenerate = (area_raw == '0) || (bb_xmin > bb_xmax) || (bb_ymin > bb_ymax);

    // ---------------- control ----------------
    logic accept, setup_go, out_free, advance, covered, row_end, last_pixel;

    assign accept     = (state_reg == IDLE) && in_valid;
    assign setup_go   = (state_reg == SETUP) && !degenerate;
    assign out_free   = !out_valid_reg || out_ready;
    assign advance    = (state_reg == SCAN) && out_free;
    assign covered    = !w_reg[0][EDGE_W-1] && !w_reg[1][EDGE_W-1] && !w_reg[2][EDGE_W-1];
    assign row_end    = (x_reg == xmax_reg);
    assign last_pixel = row_end && (y_reg == ymax_reg);

    // Sequencing: tri_done is raised in the cycle the output register is empty
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= IDLE;
            tri_done_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    tri_done_reg <= 1'b0;
                    if (in_valid) state_reg <= SETUP;
                end
                SETUP: begin
                    if (degenerate) begin
                        state_reg    <= DRAIN;
                        tri_done_reg <= 1'b1;
                    end else begin
                        state_reg <= SCAN;
                    end
                end
                SCAN: begin
                    if (advance && last_pixel) begin
                        state_reg    <= DRAIN;
                        // an uncovered final pixel leaves the output register empty
                        tri_done_reg <= !covered;
                    end
                end
                DRAIN: begin
                    if (tri_done_reg) begin
                        tri_done_reg <= 1'b0;
                        state_reg    <= IDLE;
                    end else if (out_free) begin
                        tri_done_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Capture the triangle on the input handshake
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < 3; k++) begin
                vx_reg[k] <= '0;
                vy_reg[k] <= '0;
            end
            color_reg <= '0;
            depth_reg <= '0;
            base_reg  <= '0;
        end else if (accept) begin
            vx_reg[0] <= x1;
            vy_reg[0] <= y1;
            vx_reg[1] <= x2;
            vy_reg[1] <= y2;
            vx_reg[2] <= x3;
            vy_reg[2] <= y3;
            color_reg <= color_in;
            depth_reg <= depth_in;
            base_reg  <= base_addr;
        end
    end

    // Bounding-box walk with incremental edge updates
    always_ff @(posedge clock) begin
        if (reset) begin
            x_reg    <= '0;
            y_reg    <= '0;
            xmin_reg <= '0;
            xmax_reg <= '0;
            ymax_reg <= '0;
            area_reg <= '0;
            for (int k = 0; k < 3; k++) begin
                w_reg[k]   <= '0;
                row_reg[k] <= '0;
                sx_reg[k]  <= '0;
                sy_reg[k]  <= '0;
            end
        end else if (setup_go) begin
            x_reg    <= bb_xmin;
            y_reg    <= bb_ymin;
            xmin_reg <= bb_xmin;
            xmax_reg <= bb_xmax;
            ymax_reg <= bb_ymax;
            area_reg <= neg ? -area_raw : area_raw;
            for (int k = 0; k < 3; k++) begin
                w_reg[k]   <= e_init[k];
                row_reg[k] <= e_init[k];
                sx_reg[k]  <= step_x[k];
                sy_reg[k]  <= step_y[k];
            end
        end else if (advance) begin
            if (row_end) begin
                x_reg <= xmin_reg;
                y_reg <= y_reg + COORD_W'(1);
                for (int k = 0; k < 3; k++) begin
                    w_reg[k]   <= row_reg[k] + sy_reg[k];
                    row_reg[k] <= row_reg[k] + sy_reg[k];
                end
            end else begin
                x_reg <= x_reg + COORD_W'(1);
                for (int k = 0; k < 3; k++) begin
                    w_reg[k] <= w_reg[k] + sx_reg[k];
                end
            end
        end
    end

    // Output register: refilled only when empty or being consumed
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            out_addr_reg  <= '0;
            out_x_reg     <= '0;
            out_y_reg     <= '0;
            out_color_reg <= '0;
            out_depth_reg <= '0;
            out_area_reg  <= '0;
            for (int k = 0; k < 3; k++) out_w_reg[k] <= '0;
        end else if (out_free) begin
            out_valid_reg <= advance && covered;
            if (advance && covered) begin
                out_addr_reg  <= base_reg + ADDR_W'($unsigned(y_reg)) * ROW_PITCH
                               + ADDR_W'($unsigned(x_reg));
                out_x_reg     <= x_reg;
                out_y_reg     <= y_reg;
                out_color_reg <= color_reg;
                out_depth_reg <= depth_reg;
                out_area_reg  <= area_reg;
                for (int k = 0; k < 3; k++) out_w_reg[k] <= w_reg[k];
            end
        end
    end

    assign in_ready  = (state_reg == IDLE) && !reset;
    assign busy      = (state_reg != IDLE);
    assign tri_done  = tri_done_reg;
    assign out_valid = out_valid_reg;
    assign out_addr  = out_addr_reg;
    assign out_x     = out_x_reg;
    assign out_y     = out_y_reg;
    assign out_color = out_color_reg;
    assign out_depth = out_depth_reg;
    assign out_w1    = out_w_reg[0];
    assign out_w2    = out_w_reg[1];
    assign out_w3    = out_w_reg[2];
    assign out_area  = out_area_reg;

endmodule
